// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, logical/arithmetic shifts, rotates and parallel load,
// with a shift counter that pulses word_done once every WIDTH shift/rotate operations.
module univ_shift_reg #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic [CW-1:0]    shift_cnt,
    output logic             word_done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SL   = 3'b001;
    localparam logic [2:0] MODE_SRL  = 3'b010;
    localparam logic [2:0] MODE_SRA  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_LOAD = 3'b110;

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_done;

    logic [WIDTH-1:0] w_next_q;
    logic             w_is_shift;
    logic             w_is_load;

    always_comb begin
        w_next_q   = r_q;
        w_is_shift = 1'b0;
        w_is_load  = 1'b0;
        case (mode)
            MODE_HOLD: w_next_q = r_q;
            MODE_SL: begin
                w_next_q   = {r_q[WIDTH-2:0], sin_r};
                w_is_shift = 1'b1;
            end
            MODE_SRL: begin
                w_next_q   = {sin_l, r_q[WIDTH-1:1]};
                w_is_shift = 1'b1;
            end
            MODE_SRA: begin
                w_next_q   = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                w_is_shift = 1'b1;
            end
            MODE_ROL: begin
                w_next_q   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_is_shift = 1'b1;
            end
            MODE_ROR: begin
                w_next_q   = {r_q[0], r_q[WIDTH-1:1]};
                w_is_shift = 1'b1;
            end
            MODE_LOAD: begin
                w_next_q  = din;
                w_is_load = 1'b1;
            end
            default: w_next_q = r_q;  // reserved code behaves as hold
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_q    <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (!en) begin
            r_done <= 1'b0;
        end else begin
            r_q <= w_next_q;
            if (w_is_shift) begin
                // The WIDTH-th shift wraps the counter and frames one word
                if (r_cnt == LAST_CNT) begin
                    r_cnt  <= '0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_done <= 1'b0;
                end
            end else if (w_is_load) begin
                r_cnt  <= '0;
                r_done <= 1'b0;
            end else begin
                r_done <= 1'b0;
            end
        end
    end

    assign q         = r_q;
    assign sout_msb  = r_q[WIDTH-1];
    assign sout_lsb  = r_q[0];
    assign shift_cnt = r_cnt;
    assign word_done = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH = 4: table of single-cycle vectors plus
// hand-written sequences for gaps, reserved mode and reset mid-burst.
module tb_univ_shift_reg;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clock = 1'b0;
    logic          clear;
    logic          en;
    logic [2:0]    mode;
    logic          sin_r;
    logic          sin_l;
    logic [W-1:0]  din;
    logic [W-1:0]  q;
    logic          sout_msb;
    logic          sout_lsb;
    logic [CW-1:0] shift_cnt;
    logic          word_done;

    int n_cmp  = 0;
    int n_fail = 0;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clock    (clock),
        .clear    (clear),
        .en       (en),
        .mode     (mode),
        .sin_r    (sin_r),
        .sin_l    (sin_l),
        .din      (din),
        .q        (q),
        .sout_msb (sout_msb),
        .sout_lsb (sout_lsb),
        .shift_cnt(shift_cnt),
        .word_done(word_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          clr;
        logic          en;
        logic [2:0]    mode;
        logic          sr;
        logic          sl;
        logic [W-1:0]  din;
        logic [W-1:0]  eq;
        logic [CW-1:0] ecnt;
        logic          edone;
    } vec_t;

    vec_t vecs[$];

    // Apply inputs on the falling edge, then sample 1 time unit after the rising edge
    task automatic step(input logic c, input logic e, input logic [2:0] m,
                        input logic sr, input logic sl, input logic [W-1:0] d);
        @(negedge clock);
        clear = c; en = e; mode = m; sin_r = sr; sin_l = sl; din = d;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] eq,
                         input logic [CW-1:0] ecnt, input logic edone);
        n_cmp++;
        if (q !== eq || shift_cnt !== ecnt || word_done !== edone ||
            sout_msb !== eq[W-1] || sout_lsb !== eq[0]) begin
            n_fail++;
            $display("FAIL %s: got q=%b cnt=%0d done=%b msb=%b lsb=%b, want q=%b cnt=%0d done=%b",
                     name, q, shift_cnt, word_done, sout_msb, sout_lsb, eq, ecnt, edone);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", name, got, want);
        end
    endtask

    logic [7:0] serial_bits;

    initial begin
        clear = 1'b0; en = 1'b0; mode = 3'b000; sin_r = 1'b0; sin_l = 1'b0; din = '0;

        // Reset vs load, serial SL burst, SRA/SRL, rotates, load restart, hold/en=0
        vecs.push_back('{1'b1, 1'b1, 3'b110, 1'b0, 1'b0, 4'b1111, 4'b0000, 3'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd2, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 4'b0000, 4'b0001, 3'd3, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 4'b0000, 4'b0011, 3'd0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 4'b0000, 4'b0110, 3'd1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 4'b0000, 4'b1100, 3'd2, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 4'b0000, 4'b1001, 3'd3, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 4'b0000, 4'b0011, 3'd0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 4'b1001, 4'b1001, 3'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b011, 1'b0, 1'b1, 4'b0000, 4'b1100, 3'd1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 4'b0000, 4'b1110, 3'd2, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 4'b0000, 4'b0111, 3'd3, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 4'b1011, 4'b1011, 3'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 4'b0000, 4'b0111, 3'd1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 4'b0000, 4'b1011, 3'd2, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 4'b0000, 4'b1000, 3'd1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 4'b1111, 4'b1000, 3'd1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 3'b110, 1'b1, 1'b1, 4'b0101, 4'b1000, 3'd1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 4'b0000, 4'b0100, 3'd2, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 4'b0000, 4'b1000, 3'd3, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 4'b0000, 4'b1100, 3'd0, 1'b1});

        foreach (vecs[i]) begin
            step(vecs[i].clr, vecs[i].en, vecs[i].mode, vecs[i].sr, vecs[i].sl, vecs[i].din);
            check($sformatf("vec%0d", i), vecs[i].eq, vecs[i].ecnt, vecs[i].edone);
        end

        // Serial stream: bit on sin_r emerges on sout_msb after WIDTH enabled shifts
        serial_bits = 8'b1100_1011;
        step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 3'b001, serial_bits[i], 1'b0, 4'b0000);
            if (i >= W - 1)
                check_bit($sformatf("stream%0d", i), sout_msb, serial_bits[i-(W-1)]);
        end

        // Gaps and reserved mode stall data and counter
        step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 4'b0000);
        check("gap_clr", 4'b0000, 3'd0, 1'b0);
        step(1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 4'b0000);
        check("gap_sl1", 4'b0001, 3'd1, 1'b0);
        step(1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 4'b0000);
        check("gap_off1", 4'b0001, 3'd1, 1'b0);
        step(1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 4'b0000);
        check("gap_sl2", 4'b0011, 3'd2, 1'b0);
        step(1'b0, 1'b1, 3'b111, 1'b0, 1'b1, 4'b1010);
        check("gap_rsv", 4'b0011, 3'd2, 1'b0);
        step(1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 4'b0000);
        check("gap_sl3", 4'b0111, 3'd3, 1'b0);
        step(1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 4'b0000);
        check("gap_off2", 4'b0111, 3'd3, 1'b0);
        step(1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 4'b0000);
        check("gap_sl4", 4'b1111, 3'd0, 1'b1);
        step(1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 4'b0000);
        check("gap_pulse_end", 4'b1111, 3'd0, 1'b0);

        // Reset mid-burst discards the partial count
        step(1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 4'b0000);
        check("mid_pre", 4'b0011, 3'd2, 1'b0);
        step(1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 4'b0000);
        check("mid_clr", 4'b0000, 3'd0, 1'b0);
        step(1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 4'b0000);
        check("mid_sl1", 4'b0001, 3'd1, 1'b0);
        step(1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 4'b0000);
        check("mid_sl2", 4'b0011, 3'd2, 1'b0);
        step(1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 4'b0000);
        check("mid_sl3", 4'b0111, 3'd3, 1'b0);
        step(1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 4'b0000);
        check("mid_sl4", 4'b1111, 3'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
